cpu_ctrl_fsm: RTL

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_fsm.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/writeback
// sequencing, halt-at-boundary handling, sticky illegal-opcode flag and a
// retired-instruction counter.
module cpu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op_class,
  input  logic        branch_taken,
  input  logic        mem_ready,
  input  logic        halt_button,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        pc_src,
  output logic        alu_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mdr_load,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] C_NOP    = 3'd0;
  localparam logic [2:0] C_ALU    = 3'd1;
  localparam logic [2:0] C_LOAD   = 3'd2;
  localparam logic [2:0] C_STORE  = 3'd3;
  localparam logic [2:0] C_BRANCH = 3'd4;
  localparam logic [2:0] C_JUMP   = 3'd5;
  localparam logic [2:0] C_HALT   = 3'd6;
  localparam logic [2:0] C_ILL    = 3'd7;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_class;
  logic        r_illegal;
  logic        r_halt_pending;
  logic [15:0] r_retired;

  logic w_boundary;
  logic w_halt_req;
  logic w_ir_load, w_pc_inc, w_pc_load, w_pc_src, w_alu_en;
  logic w_mem_rd, w_mem_wr, w_mdr_load, w_rf_we, w_wb_sel, w_halted;

  // Next-state and strobe decode; a completed instruction redirects to HALT
  // when a halt has been requested (now or earlier).
  always_comb begin
    w_next     = r_state;
    w_boundary = 1'b0;
    w_ir_load  = 1'b0;
    w_pc_inc   = 1'b0;
    w_pc_load  = 1'b0;
    w_pc_src   = 1'b0;
    w_alu_en   = 1'b0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_mdr_load = 1'b0;
    w_rf_we    = 1'b0;
    w_wb_sel   = 1'b0;
    w_halted   = 1'b0;
    w_halt_req = r_halt_pending | halt_button;
    case (r_state)
      S_FETCH: begin
        w_mem_rd = 1'b1;
        if (mem_ready) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_pc_inc = 1'b1;
        case (op_class)
          C_NOP, C_ILL: begin
            w_next     = S_FETCH;
            w_boundary = 1'b1;
          end
          C_HALT: begin
            w_next     = S_HALT;
            w_boundary = 1'b1;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_alu_en = 1'b1;
        case (r_class)
          C_ALU:           w_next = S_WB;
          C_LOAD, C_STORE: w_next = S_MEM;
          C_BRANCH: begin
            w_pc_load  = branch_taken;
            w_next     = S_FETCH;
            w_boundary = 1'b1;
          end
          C_JUMP: begin
            w_pc_load  = 1'b1;
            w_pc_src   = 1'b1;
            w_next     = S_FETCH;
            w_boundary = 1'b1;
          end
          // EXEC is never entered with another class; recover quietly.
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (r_class == C_LOAD) begin
          w_mem_rd = 1'b1;
          if (mem_ready) begin
            w_mdr_load = 1'b1;
            w_next     = S_WB;
          end
        end else begin
          w_mem_wr = 1'b1;
          if (mem_ready) begin
            w_next     = S_FETCH;
            w_boundary = 1'b1;
          end
        end
      end
      S_WB: begin
        w_rf_we    = 1'b1;
        w_wb_sel   = (r_class == C_LOAD);
        w_next     = S_FETCH;
        w_boundary = 1'b1;
      end
      S_HALT: begin
        w_halted = 1'b1;
        w_next   = S_HALT;
      end
      // Unused codes recover to FETCH without counting an instruction.
      default: w_next = S_FETCH;
    endcase
    if (w_boundary && (w_next == S_FETCH) && w_halt_req) begin
      w_next = S_HALT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // Instruction class captured in DECODE for use by later states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_class <= C_NOP;
    else if (r_state == S_DECODE)   r_class <= op_class;
  end

  // Sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              r_illegal <= 1'b0;
    else if ((r_state == S_DECODE) && (op_class == C_ILL)) r_illegal <= 1'b1;
  end

  // Halt request remembered until the FSM parks in HALT (left only by reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_halt_pending <= 1'b0;
    else if (halt_button && (r_state != S_HALT))  r_halt_pending <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_retired <= 16'd0;
    else if (w_boundary) r_retired <= r_retired + 16'd1;
  end

  // Strobes are forced low while reset is held, since FETCH would drive mem_rd.
  assign ir_load  = rst & w_ir_load;
  assign pc_inc   = rst & w_pc_inc;
  assign pc_load  = rst & w_pc_load;
  assign pc_src   = rst & w_pc_src;
  assign alu_en   = rst & w_alu_en;
  assign mem_rd   = rst & w_mem_rd;
  assign mem_wr   = rst & w_mem_wr;
  assign mdr_load = rst & w_mdr_load;
  assign rf_we    = rst & w_rf_we;
  assign wb_sel   = rst & w_wb_sel;
  assign halted   = rst & w_halted;
  assign illegal  = r_illegal;
  assign state    = r_state;
  assign retired  = r_retired;

endmodule
